spi_cmd_master: RTL and testbench

SPI_CMD_MASTER -- requirements
Module: spi_cmd_master

---
 rtl/spi_cmd_master.sv | 205 ++++++++++++++++++++
 tb/tb_spi_cmd_master.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_master.sv
// SPI mode-0 command master: sends a 1- or 3-byte frame MSB first, with cs_n toggled around every byte.
// Define SPI_MISO_CAPTURE_EN to capture miso into rx_byte/rx_valid; otherwise both outputs are tied to zero.
module spi_cmd_master #(
   parameter int SCLK_HALF = 2,
   parameter int CS_SETUP  = 5,
   parameter int CS_HOLD   = 5,
   parameter int GAP       = 5
) (
   input  logic        clk_in,
   input  logic        sys_rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_code,
   input  logic [15:0] cmd_data,
   input  logic        cmd_has_data,
   output logic        sclk,
   output logic        mosi,
   output logic        cs_n,
   input  logic        miso,
   output logic [7:0]  rx_byte,
   output logic        rx_valid,
   output logic        busy,
   output logic        done
);

   localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
   localparam logic [7:0] HALF_LAST  = 8'(SCLK_HALF - 1);
   localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
   localparam logic [7:0] GAP_LAST   = 8'(GAP - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SCLK_LO,
      ST_SCLK_HI,
      ST_HOLD,
      ST_GAP
   } state_t;

   state_t      state;
   logic [7:0]  cyc_cnt;
   logic [2:0]  bit_cnt;
   logic [1:0]  byte_idx;
   logic [7:0]  tx_byte;
   logic [15:0] data_q;
   logic        has_data_q;

   logic [7:0]  cyc_lim;
   logic        cyc_last;
   logic        last_byte;
   logic [7:0]  next_byte;
   logic        hold_entry;

   // mosi is the top bit of the transmit shifter, which only shifts on the sclk falling edge
   assign mosi = tx_byte[7];

   always_comb begin
      cyc_lim = 8'd0;
      case (state)
         ST_SETUP:   cyc_lim = SETUP_LAST;
         ST_SCLK_LO: cyc_lim = HALF_LAST;
         ST_SCLK_HI: cyc_lim = HALF_LAST;
         ST_HOLD:    cyc_lim = HOLD_LAST;
         ST_GAP:     cyc_lim = GAP_LAST;
         default:    cyc_lim = 8'd0;
      endcase
   end

   assign cyc_last   = (cyc_cnt == cyc_lim);
   assign last_byte  = !has_data_q || (byte_idx == 2'd2);
   assign hold_entry = (state == ST_SCLK_HI) && cyc_last && (bit_cnt == 3'd7);

   always_comb begin
      next_byte = data_q[7:0];
      if (byte_idx == 2'd1) next_byte = data_q[15:8];
   end

   always_ff @(posedge clk_in or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state      <= ST_IDLE;
         cyc_cnt    <= 8'd0;
         bit_cnt    <= 3'd0;
         byte_idx   <= 2'd0;
         tx_byte    <= 8'd0;
         data_q     <= 16'd0;
         has_data_q <= 1'b0;
         cmd_ready  <= 1'b0;
         cs_n       <= 1'b1;
         sclk       <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  data_q     <= cmd_data;
                  has_data_q <= cmd_has_data;
                  tx_byte    <= cmd_code;
                  byte_idx   <= 2'd0;
                  cyc_cnt    <= 8'd0;
                  cs_n       <= 1'b0;
                  sclk       <= 1'b0;
                  busy       <= 1'b1;
                  cmd_ready  <= 1'b0;
                  state      <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (cyc_last) begin
                  cyc_cnt <= 8'd0;
                  bit_cnt <= 3'd0;
                  state   <= ST_SCLK_LO;
               end else begin
                  cyc_cnt <= cyc_cnt + 8'd1;
               end
            end
            ST_SCLK_LO: begin
               if (cyc_last) begin
                  cyc_cnt <= 8'd0;
                  sclk    <= 1'b1;
                  state   <= ST_SCLK_HI;
               end else begin
                  cyc_cnt <= cyc_cnt + 8'd1;
               end
            end
            ST_SCLK_HI: begin
               if (cyc_last) begin
                  cyc_cnt <= 8'd0;
                  sclk    <= 1'b0;
                  if (bit_cnt == 3'd7) begin
                     state <= ST_HOLD;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     tx_byte <= {tx_byte[6:0], 1'b0};
                     state   <= ST_SCLK_LO;
                  end
               end else begin
                  cyc_cnt <= cyc_cnt + 8'd1;
               end
            end
            ST_HOLD: begin
               if (cyc_last) begin
                  cyc_cnt <= 8'd0;
                  cs_n    <= 1'b1;
                  state   <= ST_GAP;
               end else begin
                  cyc_cnt <= cyc_cnt + 8'd1;
               end
            end
            ST_GAP: begin
               if (cyc_last) begin
                  cyc_cnt <= 8'd0;
                  if (last_byte) begin
                     done      <= 1'b1;
                     busy      <= 1'b0;
                     cmd_ready <= 1'b1;
                     state     <= ST_IDLE;
                  end else begin
                     byte_idx <= byte_idx + 2'd1;
                     tx_byte  <= next_byte;
                     cs_n     <= 1'b0;
                     state    <= ST_SETUP;
                  end
               end else begin
                  cyc_cnt <= cyc_cnt + 8'd1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef SPI_MISO_CAPTURE_EN
   logic [7:0] rx_shift;

   // miso is sampled on the same edge that raises sclk, so the slave has had a full low half-period
   always_ff @(posedge clk_in or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rx_shift <= 8'd0;
         rx_byte  <= 8'd0;
         rx_valid <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if ((state == ST_SCLK_LO) && cyc_last) rx_shift <= {rx_shift[6:0], miso};
         if (hold_entry) begin
            rx_byte  <= rx_shift;
            rx_valid <= 1'b1;
         end
      end
   end
`else
   logic unused_miso;
   logic unused_hold_entry;

   assign unused_miso       = miso;
   assign unused_hold_entry = hold_entry;
   assign rx_byte           = 8'd0;
   assign rx_valid          = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cmd_master.sv
// Scoreboard bench for spi_cmd_master: random frames, miso looped back from mosi, mid-frame reset.
module tb_spi_cmd_master;
   localparam int SCLK_HALF = 2;
   localparam int CS_SETUP  = 5;
   localparam int CS_HOLD   = 5;
   localparam int GAP       = 5;
   localparam int BYTE_P    = CS_SETUP + 16 * SCLK_HALF + CS_HOLD + GAP;
   localparam int CS_LOW    = CS_SETUP + 16 * SCLK_HALF + CS_HOLD;

   logic        clk_in = 1'b0;
   logic        sys_rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_code;
   logic [15:0] cmd_data;
   logic        cmd_has_data;
   logic        sclk;
   logic        mosi;
   logic        cs_n;
   logic        miso;
   logic [7:0]  rx_byte;
   logic        rx_valid;
   logic        busy;
   logic        done;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int bytes_seen = 0;

   logic [7:0] exp_bytes[$];
   logic [7:0] exp_rx[$];
   int         exp_done[$];

   spi_cmd_master #(
      .SCLK_HALF(SCLK_HALF),
      .CS_SETUP (CS_SETUP),
      .CS_HOLD  (CS_HOLD),
      .GAP      (GAP)
   ) dut (
      .clk_in      (clk_in),
      .sys_rst_n   (sys_rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_code    (cmd_code),
      .cmd_data    (cmd_data),
      .cmd_has_data(cmd_has_data),
      .sclk        (sclk),
      .mosi        (mosi),
      .cs_n        (cs_n),
      .miso        (miso),
      .rx_byte     (rx_byte),
      .rx_valid    (rx_valid),
      .busy        (busy),
      .done        (done)
   );

   assign miso = mosi;

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic check(input string name, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Monitor: rebuilds each cs_n window from the pins and pops the expected byte when it closes
   logic       prev_cs = 1'b1;
   logic       prev_sclk = 1'b0;
   logic       prev_mosi = 1'b0;
   logic       in_win = 1'b0;
   logic [7:0] sh = 8'd0;
   logic [7:0] eb;
   int         win_start = 0;
   int         nbits = 0;
   int         first_rise = -1;
   int         viol = 0;
   int         busy_bad = 0;
   int         ed;

   always @(negedge clk_in) begin
      if (!sys_rst_n) begin
         in_win    = 1'b0;
         prev_cs   = 1'b1;
         prev_sclk = 1'b0;
         prev_mosi = 1'b0;
      end else begin
         if (prev_cs && !cs_n) begin
            in_win     = 1'b1;
            win_start  = cyc;
            nbits      = 0;
            sh         = 8'd0;
            first_rise = -1;
            viol       = 0;
            busy_bad   = 0;
         end
         if (!cs_n) begin
            if (!busy) busy_bad++;
            if (sclk && !prev_sclk) begin
               sh = {sh[6:0], mosi};
               if (nbits == 0) first_rise = cyc - win_start;
               nbits++;
            end
            if (sclk && (mosi != prev_mosi)) viol++;
         end
         if (!prev_cs && cs_n && in_win) begin
            in_win = 1'b0;
            bytes_seen++;
            $display("byte %0h on mosi, cs_n low %0d cycles, ends cycle %0d", sh, cyc - win_start, cyc);
            if (exp_bytes.size() == 0) begin
               check("unexpected_byte", int'(sh), -1);
            end else begin
               eb = exp_bytes.pop_front();
               check("mosi_byte", int'(sh), int'(eb));
            end
            check("sclk_pulses", nbits, 8);
            check("cs_low_len", cyc - win_start, CS_LOW);
            check("first_rise", first_rise, CS_SETUP + SCLK_HALF);
            check("mosi_chg_sclk_hi", viol, 0);
            check("busy_in_window", busy_bad, 0);
`ifndef SPI_MISO_CAPTURE_EN
            check("rx_byte_zero", int'(rx_byte), 0);
`endif
         end
         if (rx_valid) begin
`ifdef SPI_MISO_CAPTURE_EN
            if (exp_rx.size() == 0) begin
               check("unexpected_rx", int'(rx_byte), -1);
            end else begin
               eb = exp_rx.pop_front();
               check("rx_byte", int'(rx_byte), int'(eb));
            end
`else
            check("rx_valid_idle", int'(rx_valid), 0);
`endif
         end
         if (done) begin
            $display("frame done at cycle %0d", cyc);
            if (exp_done.size() == 0) begin
               check("unexpected_done", cyc, -1);
            end else begin
               ed = exp_done.pop_front();
               check("done_cycle", cyc, ed);
            end
            check("ready_at_done", int'(cmd_ready), 1);
         end
         prev_cs   = cs_n;
         prev_sclk = sclk;
         prev_mosi = mosi;
      end
   end

   // Presents a frame once the DUT is ready; inputs are scrambled whenever it is not ready
   task automatic issue(input logic [7:0] c, input logic [15:0] d, input logic hd);
      int w;
      int nb;
      w = 0;
      while (!cmd_ready) begin
         cmd_valid    = 1'($urandom_range(0, 1));
         cmd_code     = 8'($urandom);
         cmd_data     = 16'($urandom);
         cmd_has_data = 1'($urandom_range(0, 1));
         @(negedge clk_in);
         w++;
         if (w > 1000) begin
            check("ready_timeout", w, 0);
            return;
         end
      end
      if ($urandom_range(0, 2) == 0) begin
         cmd_valid = 1'b0;
         repeat ($urandom_range(1, 4)) @(negedge clk_in);
      end
      cmd_valid    = 1'b1;
      cmd_code     = c;
      cmd_data     = d;
      cmd_has_data = hd;
      nb = hd ? 3 : 1;
      exp_bytes.push_back(c);
      exp_rx.push_back(c);
      if (hd) begin
         exp_bytes.push_back(d[7:0]);
         exp_bytes.push_back(d[15:8]);
         exp_rx.push_back(d[7:0]);
         exp_rx.push_back(d[15:8]);
      end
      exp_done.push_back(cyc + 1 + nb * BYTE_P);
      $display("issue code %0h data %0h has_data %0d at cycle %0d", c, d, hd, cyc);
      @(negedge clk_in);
   endtask

   task automatic check_reset_outputs();
      check("rst_cs_n", int'(cs_n), 1);
      check("rst_sclk", int'(sclk), 0);
      check("rst_mosi", int'(mosi), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_rx_valid", int'(rx_valid), 0);
      check("rst_rx_byte", int'(rx_byte), 0);
      check("rst_cmd_ready", int'(cmd_ready), 0);
   endtask

   initial begin
      int k;
      int b0;
      sys_rst_n    = 1'b0;
      cmd_valid    = 1'b0;
      cmd_code     = 8'd0;
      cmd_data     = 16'd0;
      cmd_has_data = 1'b0;
      repeat (3) @(negedge clk_in);
      check_reset_outputs();
      #2 sys_rst_n = 1'b1;
      @(negedge clk_in);
      check("ready_after_release", int'(cmd_ready), 1);

      issue(8'h91, 16'h0064, 1'b1);
      issue(8'h06, 16'hFFFF, 1'b0);
      for (int i = 0; i < 10; i++) issue(8'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));

      // Abort a frame in the second byte's sclk-high phase
      issue(8'hA5, 16'h3C5A, 1'b1);
      cmd_valid = 1'b0;
      b0 = bytes_seen;
      for (k = 0; k < 400; k++) begin
         if ((bytes_seen == b0 + 1) && sclk && !cs_n) break;
         @(negedge clk_in);
      end
      check("reach_byte2_hi", int'(k < 400), 1);
      #2 sys_rst_n = 1'b0;
      #1;
      check("abort_cs_n", int'(cs_n), 1);
      check("abort_sclk", int'(sclk), 0);
      exp_bytes.delete();
      exp_rx.delete();
      exp_done.delete();
      @(negedge clk_in);
      repeat (2) @(negedge clk_in);
      check_reset_outputs();
      #2 sys_rst_n = 1'b1;
      @(negedge clk_in);
      check("ready_after_abort", int'(cmd_ready), 1);

      issue(8'h9C, 16'h4001, 1'b1);
      for (int i = 0; i < 4; i++) issue(8'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));

      cmd_valid = 1'b0;
      for (k = 0; k < 2000; k++) begin
         if ((exp_done.size() == 0) && (exp_bytes.size() == 0)) break;
         @(negedge clk_in);
      end
      repeat (60) @(negedge clk_in);
      check("drain_left", exp_done.size() + exp_bytes.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
